// File: rtl/capture_gate_pkg.sv
// capture_gate_pkg: FSM state type and per-lane masking helper shared by capture_gate.
package capture_gate_pkg;

    localparam int unsigned LANE_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        GATE  = 2'd2
    } state_t;

    // Keep the nbits MSBs of a lane and clear the rest.
    function automatic logic [LANE_W-1:0] lane_mask(input logic [LANE_W-1:0] lane,
                                                    input int unsigned       nbits);
        logic [LANE_W-1:0] mask;
        mask = {LANE_W{1'b1}} << (LANE_W - nbits);
        return lane & mask;
    endfunction

endpackage

// File: rtl/capture_gate.sv
// capture_gate: trigger-delayed capture window on a free-running ADC stream.
// Optional: define CAPTURE_GATE_RETRIG_EN to let a trigger during GATE extend the window.
module capture_gate
    import capture_gate_pkg::*;
#(
    parameter int unsigned NSAMP    = 8,
    parameter int unsigned NBITS    = 12,
    parameter int unsigned DLY_BITS = 8,
    parameter int unsigned LEN_BITS = 10
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     capture_i,
    input  logic [DLY_BITS-1:0]      delay_i,
    input  logic [LEN_BITS-1:0]      length_i,
    input  logic [LANE_W*NSAMP-1:0]  adc_tdata,
    input  logic                     adc_tvalid,
    output logic                     adc_tready,
    output logic [LANE_W*NSAMP-1:0]  gate_tdata,
    output logic                     gate_tvalid,
    input  logic                     gate_tready,
    output logic                     busy_o,
    output logic                     done_o
);

    localparam int unsigned DATA_W = LANE_W * NSAMP;
    localparam int unsigned CNT_W  = (DLY_BITS > LEN_BITS) ? DLY_BITS : LEN_BITS;

    typedef logic [CNT_W-1:0] cnt_t;

    state_t              r_state;
    state_t              w_state_next;
    cnt_t                r_cnt;
    cnt_t                w_cnt_next;
    logic [LEN_BITS-1:0] r_len;
    logic [LEN_BITS-1:0] w_len_next;
    logic                r_capture_q;
    logic [DATA_W-1:0]   r_tdata;
    logic [DATA_W-1:0]   w_tdata_next;
    logic                r_tvalid;
    logic                r_done;
    logic                w_done_next;
    logic                w_trig;
    logic                w_retrig;
    logic                w_cnt_last;
    logic                w_len_zero;
    logic [DATA_W-1:0]   w_masked;
    logic                w_unused;

    // The sink never stalls; downstream back-pressure is not honoured.
    assign adc_tready = 1'b1;
    assign w_unused   = gate_tready;

    assign w_trig     = capture_i & ~r_capture_q;
    assign w_cnt_last = (r_cnt == cnt_t'(1));
    assign w_len_zero = (length_i == '0);

`ifdef CAPTURE_GATE_RETRIG_EN
    // A zero-length retrigger would leave no window to extend, so it is dropped.
    assign w_retrig = w_trig & (r_state == GATE) & ~w_len_zero;
`else
    assign w_retrig = 1'b0;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NSAMP; gi++) begin : g_lane
            assign w_masked[gi*LANE_W +: LANE_W] = lane_mask(adc_tdata[gi*LANE_W +: LANE_W], NBITS);
        end
    endgenerate

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_len       <= '0;
            r_capture_q <= 1'b1;
            r_tdata     <= '0;
            r_tvalid    <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_len       <= w_len_next;
            r_capture_q <= capture_i;
            r_tdata     <= w_tdata_next;
            r_tvalid    <= 1'b1;
            r_done      <= w_done_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_len_next   = r_len;
        case (r_state)
            IDLE: begin
                if (w_trig && !w_len_zero) begin
                    w_len_next = length_i;
                    if (delay_i == '0) begin
                        w_state_next = GATE;
                        w_cnt_next   = cnt_t'(length_i);
                    end else begin
                        w_state_next = DELAY;
                        w_cnt_next   = cnt_t'(delay_i);
                    end
                end
            end
            DELAY: begin
                if (w_cnt_last) begin
                    w_state_next = GATE;
                    w_cnt_next   = cnt_t'(r_len);
                end else begin
                    w_cnt_next = r_cnt - cnt_t'(1);
                end
            end
            GATE: begin
                if (w_retrig) begin
                    w_cnt_next = cnt_t'(length_i);
                    w_len_next = length_i;
                end else if (w_cnt_last) begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt - cnt_t'(1);
                end
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        w_tdata_next = '0;
        w_done_next  = 1'b0;
        if (r_state == GATE && adc_tvalid) begin
            w_tdata_next = w_masked;
        end
        if (r_state == IDLE && w_trig && w_len_zero) begin
            w_done_next = 1'b1;
        end else if (r_state == GATE && w_cnt_last && !w_retrig) begin
            w_done_next = 1'b1;
        end
    end

    assign gate_tdata  = r_tdata;
    assign gate_tvalid = r_tvalid;
    assign busy_o      = (r_state != IDLE);
    assign done_o      = r_done;

endmodule

// File: tb/tb_capture_gate.sv
// tb_capture_gate: randomized + directed scoreboard bench; the reference model tracks
// capture windows as absolute edge ranges [start, end] rather than a counter FSM.
module tb_capture_gate;

    localparam int NSAMP    = 8;
    localparam int NBITS    = 12;
    localparam int DLY_BITS = 8;
    localparam int LEN_BITS = 10;
    localparam int W        = 16 * NSAMP;

    typedef struct packed {
        logic [W-1:0] data;
        logic         done;
        logic         busy;
    } exp_t;

    logic                aclk = 1'b0;
    logic                aresetn = 1'b0;
    logic                capture_i = 1'b1;
    logic [DLY_BITS-1:0] delay_i = '0;
    logic [LEN_BITS-1:0] length_i = '0;
    logic [W-1:0]        adc_tdata = '0;
    logic                adc_tvalid = 1'b0;
    logic                adc_tready;
    logic [W-1:0]        gate_tdata;
    logic                gate_tvalid;
    logic                gate_tready = 1'b0;
    logic                busy_o;
    logic                done_o;

    int n_tests = 0;
    int n_fail  = 0;

    exp_t sb[$];

    // Reference model state: absolute edge index, active window bounds.
    int m_k    = 0;
    bit m_act  = 0;
    int m_ws   = 0;
    int m_we   = 0;
    bit m_capq = 1;
    int ramp   = 0;

    capture_gate #(
        .NSAMP(NSAMP), .NBITS(NBITS), .DLY_BITS(DLY_BITS), .LEN_BITS(LEN_BITS)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .capture_i(capture_i),
        .delay_i(delay_i), .length_i(length_i),
        .adc_tdata(adc_tdata), .adc_tvalid(adc_tvalid), .adc_tready(adc_tready),
        .gate_tdata(gate_tdata), .gate_tvalid(gate_tvalid), .gate_tready(gate_tready),
        .busy_o(busy_o), .done_o(done_o)
    );

    always #5 aclk = ~aclk;

    function automatic logic [W-1:0] mask_beat(input logic [W-1:0] d);
        logic [W-1:0] r;
        logic [15:0]  keep;
        keep = 16'hFFFF << (16 - NBITS);
        for (int i = 0; i < NSAMP; i++) r[i*16 +: 16] = d[i*16 +: 16] & keep;
        return r;
    endfunction

    function automatic logic [W-1:0] ramp_beat(input int base);
        logic [W-1:0] r;
        for (int i = 0; i < NSAMP; i++) r[i*16 +: 16] = 16'((base * NSAMP + i) * 16'h0123 + 7);
        return r;
    endfunction

    function automatic logic [W-1:0] rand_beat();
        logic [W-1:0] r;
        for (int i = 0; i < NSAMP; i++) r[i*16 +: 16] = 16'($urandom);
        return r;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, got, want);
        end
    endtask

    task automatic ref_step(input logic cap, input int d, input int l,
                            input logic v, input logic [W-1:0] data);
        exp_t e;
        bit   trig;
        trig   = cap && !m_capq;
        m_capq = cap;
        e.data = '0;
        e.done = 1'b0;
        if (m_act) begin
            if (m_k >= m_ws && v) e.data = mask_beat(data);
`ifdef CAPTURE_GATE_RETRIG_EN
            if (trig && m_k >= m_ws && l != 0) m_we = m_k + l;
`endif
            if (m_k == m_we) begin
                e.done = 1'b1;
                m_act  = 0;
            end
        end else if (trig) begin
            if (l == 0) begin
                e.done = 1'b1;
            end else begin
                m_act = 1;
                m_ws  = m_k + d + 1;
                m_we  = m_k + d + l;
            end
        end
        e.busy = m_act;
        m_k++;
        sb.push_back(e);
    endtask

    task automatic step(input logic cap, input int d, input int l,
                        input logic v, input logic [W-1:0] data);
        @(negedge aclk);
        aresetn    = 1'b1;
        capture_i  = cap;
        delay_i    = DLY_BITS'(d);
        length_i   = LEN_BITS'(l);
        adc_tvalid = v;
        adc_tdata  = data;
        ref_step(cap, d, l, v, data);
    endtask

    // Idle cycles with ramp data and scrambled delay/length (must not disturb a running capture).
    task automatic idle_ramp(input int n, input logic cap);
        for (int i = 0; i < n; i++) begin
            step(cap, $urandom_range(0, 9), $urandom_range(0, 15), 1'b1, ramp_beat(ramp));
            ramp++;
        end
    endtask

    task automatic reset_for(input int n, input logic cap);
        for (int i = 0; i < n; i++) begin
            @(negedge aclk);
            aresetn    = 1'b0;
            capture_i  = cap;
            adc_tvalid = 1'b1;
            adc_tdata  = rand_beat();
            m_act      = 0;
            m_capq     = 1;
            if (i == 0) begin
                #1;
                chk("async_rst_tdata", gate_tdata, '0);
                chk("async_rst_busy",  W'(busy_o), '0);
                chk("async_rst_done",  W'(done_o), '0);
            end
        end
    endtask

    // Monitor: one scoreboard entry per clock edge while out of reset.
    initial begin
        exp_t e;
        forever begin
            @(posedge aclk);
            #1;
            if (!aresetn) begin
                chk("rst_tdata",  gate_tdata, '0);
                chk("rst_tvalid", W'(gate_tvalid), '0);
                chk("rst_busy",   W'(busy_o), '0);
                chk("rst_done",   W'(done_o), '0);
            end else if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_empty @%0t: got no expectation, required one per edge", $time);
            end else begin
                e = sb.pop_front();
                chk("tdata",  gate_tdata, e.data);
                chk("tvalid", W'(gate_tvalid), W'(1));
                chk("tready", W'(adc_tready), W'(1));
                chk("busy",   W'(busy_o), W'(e.busy));
                chk("done",   W'(done_o), W'(e.done));
                if (e.done) $display("[TB] capture closed @%0t", $time);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic cap_r;
        // Reset with capture high, released while still high: no trigger.
        reset_for(3, 1'b1);
        idle_ramp(4, 1'b1);
        idle_ramp(3, 1'b0);

        // D=3 L=4 ramp data.
        step(1'b1, 3, 4, 1'b1, ramp_beat(ramp)); ramp++;
        idle_ramp(1, 1'b1);
        idle_ramp(10, 1'b0);

        // D=0 L=1.
        step(1'b1, 0, 1, 1'b1, ramp_beat(ramp)); ramp++;
        idle_ramp(5, 1'b0);

        // L=0 D=5: immediate done, never busy.
        step(1'b1, 5, 0, 1'b1, ramp_beat(ramp)); ramp++;
        idle_ramp(9, 1'b0);

        // All-ones lanes: passed lanes become FFF0.
        step(1'b1, 1, 3, 1'b1, {W{1'b1}});
        for (int i = 0; i < 6; i++) step(1'b0, 2, 7, 1'b1, {W{1'b1}});

        // Retrigger at E0+5 with D=2 L=4.
        step(1'b1, 2, 4, 1'b1, ramp_beat(ramp)); ramp++;
        idle_ramp(4, 1'b0);
        step(1'b1, 2, 4, 1'b1, ramp_beat(ramp)); ramp++;
        idle_ramp(8, 1'b0);

        // Retrigger during DELAY is always ignored.
        step(1'b1, 4, 3, 1'b1, ramp_beat(ramp)); ramp++;
        idle_ramp(1, 1'b0);
        step(1'b1, 0, 9, 1'b1, ramp_beat(ramp)); ramp++;
        idle_ramp(8, 1'b0);

        // Reset mid-capture (D=2 L=8), capture held high through release.
        step(1'b1, 2, 8, 1'b1, ramp_beat(ramp)); ramp++;
        idle_ramp(3, 1'b0);
        reset_for(2, 1'b1);
        idle_ramp(4, 1'b1);
        idle_ramp(12, 1'b0);

        // Randomized traffic with occasional resets.
        cap_r = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                reset_for($urandom_range(1, 3), cap_r);
            end else begin
                if ($urandom_range(0, 6) == 0) cap_r = ~cap_r;
                step(cap_r, $urandom_range(0, 6), $urandom_range(0, 12),
                     1'($urandom_range(0, 3) != 0), rand_beat());
            end
        end
        idle_ramp(30, 1'b0);

        @(posedge aclk);
        #2;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d pending entries, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/capture_gate.md
CAPTURE_GATE -- requirements
Module: capture_gate

Interface
REQ-001 SHALL have parameter NSAMP, default 8: number of 16-bit sample lanes per beat.
REQ-002 SHALL have parameter NBITS, default 12: significant MSBs per lane; the remaining 16-NBITS LSBs are forced to zero on output.
REQ-003 SHALL have parameter DLY_BITS, default 8: width of delay_i.
REQ-004 SHALL have parameter LEN_BITS, default 10: width of length_i.
REQ-005 SHALL have port aclk, input, 1: the single clock.
REQ-006 SHALL have port aresetn, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port capture_i, input, 1: trigger level; its rising edge starts a capture.
REQ-008 SHALL have port delay_i, input, DLY_BITS: cycles from trigger to window open; sampled on the trigger edge.
REQ-009 SHALL have port length_i, input, LEN_BITS: window length in cycles; sampled on the trigger edge.
REQ-010 SHALL have ports adc_tdata, adc_tvalid and adc_tready: input 16*NSAMP, input 1 and output 1, forming the AXI4-Stream sink.
REQ-011 SHALL have ports gate_tdata, gate_tvalid and gate_tready: output 16*NSAMP, output 1 and input 1, forming the AXI4-Stream source that feeds the biquad filter stage.
REQ-012 SHALL have port busy_o, output, 1: high while a capture is pending or open.
REQ-013 SHALL have port done_o, output, 1: one-cycle pulse at window close.

Function
REQ-014 SHALL tie adc_tready to 1 and ignore gate_tready; the ADC stream is never stalled.
REQ-015 SHALL drive gate_tvalid to 1 in every cycle outside reset.
REQ-016 SHALL register capture_i into capture_q and detect a trigger at edge E0 when capture_i=1 and capture_q=0.
REQ-017 SHALL implement FSM states IDLE, DELAY and GATE, with a single down-counter cnt of width max(DLY_BITS,LEN_BITS).
REQ-018 IDLE with trigger at E0: L=0 -> stay IDLE and pulse done_o at E0; D>0 -> go to DELAY with cnt=D; D=0 -> go to GATE with cnt=L.
REQ-019 DELAY: decrement cnt each edge; when cnt==1, go to GATE with cnt=L latched.
REQ-020 GATE: decrement cnt each edge; when cnt==1, go to IDLE and assert done_o for exactly one cycle.
REQ-021 Window: input beats sampled at edges E0+D+1 through E0+D+L SHALL pass; all others SHALL output all-zero data.
REQ-022 A passed beat SHALL appear on gate_tdata, registered, after the edge at which it is sampled; latency is 1 cycle.
REQ-023 Passed data SHALL have the low 16-NBITS bits of each lane zeroed and the upper NBITS bits unchanged.
REQ-024 A cycle inside the window with adc_tvalid=0 SHALL output zero data and still decrement cnt.
REQ-025 busy_o SHALL equal (state != IDLE).
REQ-026 A trigger while in DELAY or GATE SHALL be ignored unless CAPTURE_GATE_RETRIG_EN is defined.
REQ-027 Changes to delay_i or length_i after E0 SHALL NOT affect the current capture.

Reset
REQ-028 While aresetn=0: state=IDLE, cnt=0, gate_tdata=0, gate_tvalid=0, busy_o=0, done_o=0 and capture_q=1.
REQ-029 Because capture_q resets to 1, a capture_i held high across reset release SHALL NOT trigger.
REQ-030 Reset asserted mid-capture SHALL abort the capture immediately with no done_o pulse.

Configuration
REQ-031 With CAPTURE_GATE_RETRIG_EN defined, a trigger in GATE SHALL reload cnt=length_i, extending the window without a gap and suppressing done_o until the new end.
REQ-032 With CAPTURE_GATE_RETRIG_EN defined, a trigger in DELAY SHALL still be ignored.
REQ-033 Without CAPTURE_GATE_RETRIG_EN, triggers SHALL be ignored in both DELAY and GATE.

Structure
REQ-034 Package capture_gate_pkg SHALL hold the state enum type (IDLE/DELAY/GATE) and the lane-mask function (16-bit lane, NBITS).
REQ-035 No sub-module; the edge detect, FSM, counter and output register are all implemented in capture_gate.

Verification
REQ-036 D=3, L=4, ramp data, single trigger at E0 -> beats E0+4..E0+7 pass masked; done_o at E0+7; busy_o high E0..E0+6.
REQ-037 D=0, L=1 -> only beat E0+1 passes; done_o at E0+1.
REQ-038 L=0, D=5 -> no data passes; done_o at E0; busy_o stays 0.
REQ-039 adc_tdata lane=16'hFFFF, NBITS=12 -> passed lane=16'hFFF0; outside the window=16'h0000.
REQ-040 Second trigger at E0+5 with D=2, L=4: without CAPTURE_GATE_RETRIG_EN the window is E0+3..E0+6; with it the window is E0+3..E0+9 and done_o fires at E0+9.
REQ-041 aresetn low at E0+4 of a D=2, L=8 capture -> outputs zero, no done_o; capture_i held high through reset release -> no trigger.
